// File: rtl/spi_master.sv
// Master-side SPI engine for the vSPI command protocol: command byte, then a payload streamed
// from the transmit buffer or captured into the receive buffer, then a guaranteed SS gap.
module spi_master #(
  parameter int unsigned AddrBits   = 12,
  parameter int unsigned HalfPeriod = 4
) (
  input  logic                SysClk,
  input  logic                Reset,
  input  logic                xferStart,
  input  logic [7:0]          xferCmd,
  input  logic [AddrBits-1:0] xferLen,
  output logic                busy,
  output logic                done,
  output logic                SPI_CLK,
  output logic                SPI_MOSI,
  input  logic                SPI_MISO,
  output logic                SPI_SS,
  output logic [AddrBits-1:0] txMemAddr,
  input  logic [7:0]          txMemData,
  output logic [AddrBits-1:0] rcMemAddr,
  output logic [7:0]          rcMemData,
  output logic                rcMemWE
);

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} stateT;

  localparam logic [8:0] HalfLast = 9'(HalfPeriod - 1);
  localparam logic [8:0] GapLast  = 9'(2 * HalfPeriod - 1);

  stateT               stateQ, stateD;
  logic [8:0]          cntQ, cntD;
  logic                clkQ, clkD;
  logic                ssQ, ssD;
  logic [2:0]          bitQ, bitD;
  logic [AddrBits-1:0] byteQ, byteD;
  logic [AddrBits-1:0] lenQ;
  logic                txDirQ, rxDirQ;
  logic [7:0]          shiftQ, rxShiftQ, rcDataQ;
  logic [AddrBits-1:0] txAddrQ, rcAddrQ;
  logic                rxFullQ, weQ, doneQ, doneD;
  logic                miso_reg;
  logic                accept, rise, fall, lastBit;
  logic                isTx, isRx;

  assign isTx    = (xferCmd == 8'd1) || (xferCmd == 8'd2);
  assign isRx    = (xferCmd == 8'd3) || (xferCmd == 8'd4);
  assign lastBit = (byteQ == lenQ) && (bitQ == 3'd7);

  always_comb begin
    stateD = stateQ;
    cntD   = cntQ + 9'd1;
    clkD   = clkQ;
    ssD    = ssQ;
    bitD   = bitQ;
    byteD  = byteQ;
    doneD  = 1'b0;
    accept = 1'b0;
    rise   = 1'b0;
    fall   = 1'b0;
    case (stateQ)
      StIdle: begin
        cntD = '0;
        if (xferStart) begin
          accept = 1'b1;
          stateD = StSetup;
          ssD    = 1'b0;
          bitD   = '0;
          byteD  = '0;
        end
      end
      StSetup: begin
        if (cntQ == HalfLast) begin
          stateD = StShift;
          cntD   = '0;
          clkD   = 1'b1;
          rise   = 1'b1;
        end
      end
      StShift: begin
        if (cntQ == HalfLast) begin
          cntD = '0;
          if (clkQ) begin
            clkD = 1'b0;
            fall = 1'b1;
            bitD = bitQ + 3'd1;
            if (bitQ == 3'd7) byteD = byteQ + 1'b1;
            if (lastBit) stateD = StHold;
          end else begin
            clkD = 1'b1;
            rise = 1'b1;
          end
        end
      end
      StHold: begin
        if (cntQ == HalfLast) begin
          stateD = StGap;
          cntD   = '0;
          ssD    = 1'b1;
        end
      end
      StGap: begin
        if (cntQ == GapLast) begin
          stateD = StIdle;
          cntD   = '0;
          doneD  = 1'b1;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge SysClk) begin
    if (Reset) begin
      stateQ   <= StIdle;
      cntQ     <= '0;
      clkQ     <= 1'b0;
      ssQ      <= 1'b1;
      bitQ     <= '0;
      byteQ    <= '0;
      lenQ     <= '0;
      txDirQ   <= 1'b0;
      rxDirQ   <= 1'b0;
      shiftQ   <= '0;
      rxShiftQ <= '0;
      rcDataQ  <= '0;
      txAddrQ  <= '0;
      rcAddrQ  <= '0;
      rxFullQ  <= 1'b0;
      weQ      <= 1'b0;
      doneQ    <= 1'b0;
      miso_reg <= 1'b0;
    end else begin
      stateQ   <= stateD;
      cntQ     <= cntD;
      clkQ     <= clkD;
      ssQ      <= ssD;
      bitQ     <= bitD;
      byteQ    <= byteD;
      doneQ    <= doneD;
      miso_reg <= SPI_MISO;
      if (weQ) rcAddrQ <= rcAddrQ + 1'b1;
      if (accept) begin
        shiftQ <= xferCmd;
        lenQ   <= (isTx || isRx) ? xferLen : '0;
        txDirQ <= isTx;
        rxDirQ <= isRx;
        if (xferCmd == 8'd1) txAddrQ <= '0;
        if (xferCmd == 8'd3) rcAddrQ <= '0;
      end else if (fall) begin
        if (lastBit) begin
          shiftQ <= '0;
        end else if (bitQ == 3'd7) begin
          // Byte boundary: next payload byte, or zeros when receiving.
          if (txDirQ) begin
            shiftQ  <= txMemData;
            txAddrQ <= txAddrQ + 1'b1;
          end else begin
            shiftQ <= '0;
          end
        end else begin
          shiftQ <= {shiftQ[6:0], 1'b0};
        end
      end
      if (rise) rxShiftQ <= {rxShiftQ[6:0], miso_reg};
      // Command byte (byteQ == 0) never produces a receive write.
      rxFullQ <= rise && rxDirQ && (byteQ != '0) && (bitQ == 3'd7);
      weQ     <= rxFullQ;
      if (rxFullQ) rcDataQ <= rxShiftQ;
    end
  end

  assign busy      = (stateQ != StIdle);
  assign done      = doneQ;
  assign SPI_CLK   = clkQ;
  assign SPI_SS    = ssQ;
  assign SPI_MOSI  = shiftQ[7];
  assign txMemAddr = txAddrQ;
  assign rcMemAddr = rcAddrQ;
  assign rcMemData = rcDataQ;
  assign rcMemWE   = weQ;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master with a mode-0 peripheral model and local buffer models.
module tb_spi_master;

  logic        SysClk = 1'b0;
  logic        Reset = 1'b1;
  logic        xferStart = 1'b0;
  logic [7:0]  xferCmd = 8'd0;
  logic [11:0] xferLen = 12'd0;
  logic        busy, done, SPI_CLK, SPI_MOSI, SPI_SS, rcMemWE;
  logic        SPI_MISO;
  logic [11:0] txMemAddr, rcMemAddr;
  logic [7:0]  txMemData = 8'd0;
  logic [7:0]  rcMemData;

  logic [7:0]  txMem [0:4095];
  logic [7:0]  rcMem [0:4095];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Peripheral / monitor state, owned by the negedge monitor.
  logic        prevSs = 1'b1, prevClk = 1'b0;
  int          riseCount = 0, fallCount = 0, weCount = 0, firstRise = -1;
  logic [63:0] mosiBits = '0;
  logic        mosiHighPayload = 1'b0;
  logic [31:0] misoStream = '0;
  logic [31:0] misoSh = '0;
  logic [11:0] weAddr [0:3];

  spi_master #(.AddrBits(12), .HalfPeriod(4)) dut (
    .SysClk(SysClk), .Reset(Reset), .xferStart(xferStart), .xferCmd(xferCmd),
    .xferLen(xferLen), .busy(busy), .done(done), .SPI_CLK(SPI_CLK), .SPI_MOSI(SPI_MOSI),
    .SPI_MISO(SPI_MISO), .SPI_SS(SPI_SS), .txMemAddr(txMemAddr), .txMemData(txMemData),
    .rcMemAddr(rcMemAddr), .rcMemData(rcMemData), .rcMemWE(rcMemWE)
  );

  always #5 SysClk = ~SysClk;

  always @(posedge SysClk) begin
    cyc       <= cyc + 1;
    txMemData <= txMem[txMemAddr];
  end

  assign SPI_MISO = misoSh[31];

  always @(negedge SysClk) begin
    if (prevSs && !SPI_SS) begin
      riseCount       <= 0;
      fallCount       <= 0;
      weCount         <= 0;
      firstRise       <= -1;
      mosiBits        <= '0;
      mosiHighPayload <= 1'b0;
      misoSh          <= misoStream;
    end else begin
      if (!prevClk && SPI_CLK) begin
        riseCount <= riseCount + 1;
        mosiBits  <= {mosiBits[62:0], SPI_MOSI};
        if (riseCount == 0) firstRise <= cyc;
      end
      if (prevClk && !SPI_CLK) begin
        fallCount <= fallCount + 1;
        misoSh    <= {misoSh[30:0], 1'b0};
      end
      if (!SPI_SS && fallCount >= 8 && SPI_MOSI) mosiHighPayload <= 1'b1;
      if (rcMemWE) begin
        if (weCount < 4) weAddr[weCount] <= rcMemAddr;
        weCount          <= weCount + 1;
        rcMem[rcMemAddr] <= rcMemData;
      end
    end
    prevSs  <= SPI_SS;
    prevClk <= SPI_CLK;
  end

  task automatic start_xfer(input logic [7:0] c, input logic [11:0] l, output int t1);
    @(negedge SysClk);
    xferCmd   = c;
    xferLen   = l;
    xferStart = 1'b1;
    @(negedge SysClk);
    xferStart = 1'b0;
    t1 = cyc;
  endtask

  task automatic wait_done(input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge SysClk);
      if (done) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int ssLowSeen;
    Reset = 1'b1;
    repeat (3) @(negedge SysClk);
    Reset = 1'b0;
    checks++; if (SPI_SS !== 1'b1) begin failures++; $display("FAIL reset_ss got=%b want=1", SPI_SS); end
    checks++; if (SPI_CLK !== 1'b0) begin failures++; $display("FAIL reset_clk got=%b want=0", SPI_CLK); end
    checks++; if (SPI_MOSI !== 1'b0) begin failures++; $display("FAIL reset_mosi got=%b want=0", SPI_MOSI); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_busy_done got=%b%b want=00", busy, done); end
    checks++; if (rcMemWE !== 1'b0 || rcMemData !== 8'h00) begin failures++; $display("FAIL reset_rc got we=%b data=%h want 0/00", rcMemWE, rcMemData); end
    checks++; if (txMemAddr !== 12'd0 || rcMemAddr !== 12'd0) begin failures++; $display("FAIL reset_addr got tx=%0d rc=%0d want 0/0", txMemAddr, rcMemAddr); end
    ssLowSeen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge SysClk);
      if (SPI_SS !== 1'b1) ssLowSeen++;
    end
    checks++; if (ssLowSeen != 0) begin failures++; $display("FAIL idle_ss_high low_cycles=%0d want=0", ssLowSeen); end
  endtask

  task automatic test_tx_payload;
    int t1, at;
    txMem[0] = 8'hA5;
    txMem[1] = 8'h3C;
    start_xfer(8'd1, 12'd2, t1);
    checks++; if (busy !== 1'b1 || SPI_SS !== 1'b0 || SPI_MOSI !== 1'b0) begin failures++; $display("FAIL tx_t1 got busy=%b ss=%b mosi=%b want 1/0/0", busy, SPI_SS, SPI_MOSI); end
    // Starts and new command/length while busy must be ignored.
    repeat (20) @(negedge SysClk);
    xferCmd = 8'd3; xferLen = 12'd9; xferStart = 1'b1;
    repeat (2) @(negedge SysClk);
    xferStart = 1'b0;
    wait_done(400, at);
    checks++; if (at != t1 + 204) begin failures++; $display("FAIL tx_done_time got=%0d want=%0d", at - t1, 204); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL tx_busy_at_done got=%b want=0", busy); end
    checks++; if (mosiBits[23:0] !== 24'h01A53C) begin failures++; $display("FAIL tx_mosi got=%h want=01a53c", mosiBits[23:0]); end
    checks++; if (riseCount != 24) begin failures++; $display("FAIL tx_rises got=%0d want=24", riseCount); end
    checks++; if (firstRise != t1 + 4) begin failures++; $display("FAIL tx_first_rise got=%0d want=4", firstRise - t1); end
    checks++; if (txMemAddr !== 12'd2) begin failures++; $display("FAIL tx_addr_end got=%0d want=2", txMemAddr); end
  endtask

  task automatic test_rx_payload;
    int t1, at;
    misoStream = {8'h00, 8'h5A, 8'hC3, 8'h00};
    start_xfer(8'd3, 12'd2, t1);
    wait_done(400, at);
    checks++; if (at != t1 + 204) begin failures++; $display("FAIL rx_done_time got=%0d want=204", at - t1); end
    checks++; if (weCount != 2) begin failures++; $display("FAIL rx_we_count got=%0d want=2", weCount); end
    checks++; if (weAddr[0] !== 12'd0 || weAddr[1] !== 12'd1) begin failures++; $display("FAIL rx_we_addr got=%0d,%0d want=0,1", weAddr[0], weAddr[1]); end
    checks++; if (rcMem[0] !== 8'h5A || rcMem[1] !== 8'hC3) begin failures++; $display("FAIL rx_data got=%h,%h want=5a,c3", rcMem[0], rcMem[1]); end
    checks++; if (mosiHighPayload !== 1'b0) begin failures++; $display("FAIL rx_mosi_zero got=%b want=0", mosiHighPayload); end
    checks++; if (mosiBits[23:16] !== 8'h03) begin failures++; $display("FAIL rx_cmd_byte got=%h want=03", mosiBits[23:16]); end
    checks++; if (rcMemAddr !== 12'd2) begin failures++; $display("FAIL rx_addr_end got=%0d want=2", rcMemAddr); end
  endtask

  task automatic test_more_pointer;
    int t1, at;
    misoStream = {8'h00, 8'h11, 16'h0000};
    start_xfer(8'd3, 12'd1, t1);
    wait_done(400, at);
    checks++; if (weCount != 1 || weAddr[0] !== 12'd0 || rcMem[0] !== 8'h11) begin failures++; $display("FAIL start_write got n=%0d addr=%0d data=%h want 1/0/11", weCount, weAddr[0], rcMem[0]); end
    misoStream = {8'h00, 8'h22, 16'h0000};
    start_xfer(8'd4, 12'd1, t1);
    wait_done(400, at);
    checks++; if (weCount != 1 || weAddr[0] !== 12'd1 || rcMem[1] !== 8'h22) begin failures++; $display("FAIL more_write got n=%0d addr=%0d data=%h want 1/1/22", weCount, weAddr[0], rcMem[1]); end
    misoStream = {8'h00, 8'h33, 16'h0000};
    start_xfer(8'd3, 12'd1, t1);
    wait_done(400, at);
    checks++; if (weCount != 1 || weAddr[0] !== 12'd0 || rcMem[0] !== 8'h33) begin failures++; $display("FAIL restart_write got n=%0d addr=%0d data=%h want 1/0/33", weCount, weAddr[0], rcMem[0]); end
    checks++; if (at != t1 + 140) begin failures++; $display("FAIL len1_done_time got=%0d want=140", at - t1); end
  endtask

  task automatic test_cmd_only_back_to_back;
    int t1, at;
    start_xfer(8'd5, 12'd7, t1);
    wait_done(400, at);
    checks++; if (at != t1 + 76) begin failures++; $display("FAIL cmd_done_time got=%0d want=76", at - t1); end
    checks++; if (riseCount != 8) begin failures++; $display("FAIL cmd_rises got=%0d want=8", riseCount); end
    checks++; if (mosiBits[7:0] !== 8'h05) begin failures++; $display("FAIL cmd_mosi got=%h want=05", mosiBits[7:0]); end
    checks++; if (weCount != 0 || txMemAddr !== 12'd2 || rcMemAddr !== 12'd1) begin failures++; $display("FAIL cmd_no_mem got we=%0d tx=%0d rc=%0d want 0/2/1", weCount, txMemAddr, rcMemAddr); end
    // Start in the very cycle done is high.
    xferCmd = 8'd6; xferLen = 12'd0; xferStart = 1'b1;
    @(negedge SysClk);
    xferStart = 1'b0;
    t1 = cyc;
    checks++; if (busy !== 1'b1 || SPI_SS !== 1'b0) begin failures++; $display("FAIL b2b_accept got busy=%b ss=%b want 1/0", busy, SPI_SS); end
    wait_done(400, at);
    checks++; if (at != t1 + 76) begin failures++; $display("FAIL b2b_done_time got=%0d want=76", at - t1); end
  endtask

  task automatic test_reset_mid;
    int t1, at, doneSeen;
    txMem[2] = 8'h77;
    start_xfer(8'd1, 12'd3, t1);
    while (cyc < t1 + 50) @(negedge SysClk);
    Reset = 1'b1;
    @(negedge SysClk);
    Reset = 1'b0;
    checks++; if (SPI_SS !== 1'b1 || SPI_CLK !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mid_reset got ss=%b clk=%b busy=%b want 1/0/0", SPI_SS, SPI_CLK, busy); end
    checks++; if (txMemAddr !== 12'd0 || rcMemAddr !== 12'd0) begin failures++; $display("FAIL mid_reset_addr got tx=%0d rc=%0d want 0/0", txMemAddr, rcMemAddr); end
    doneSeen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge SysClk);
      if (done === 1'b1 || rcMemWE === 1'b1) doneSeen++;
    end
    checks++; if (doneSeen != 0) begin failures++; $display("FAIL mid_reset_quiet got=%0d want=0", doneSeen); end
    // MORE after reset must continue from pointer 0.
    start_xfer(8'd2, 12'd1, t1);
    wait_done(400, at);
    checks++; if (at != t1 + 140) begin failures++; $display("FAIL post_reset_done got=%0d want=140", at - t1); end
    checks++; if (mosiBits[15:0] !== 16'h02A5) begin failures++; $display("FAIL post_reset_mosi got=%h want=02a5", mosiBits[15:0]); end
    checks++; if (txMemAddr !== 12'd1) begin failures++; $display("FAIL post_reset_addr got=%0d want=1", txMemAddr); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_tx_payload();
    test_rx_payload();
    test_more_pointer();
    test_cmd_only_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
